// File: rtl/phy_rx_deframe.sv
// Receive deframer: strips STP/SDP..END/EDB framing from 32-bit lane-merged symbol words
// and re-aligns payload bytes onto an AXIS stream toward the DLL receive FIFO.

package phy_rx_deframe_pkg;
  typedef enum logic [2:0] {
    RateGen1 = 3'd0,
    RateGen2 = 3'd1,
    RateGen3 = 3'd2,
    RateGen4 = 3'd3,
    RateGen5 = 3'd4
  } rate_speed_e;
endpackage

module phy_rx_deframe
  import phy_rx_deframe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH    = 5,
  parameter int unsigned MAX_TLP_WORDS = 1040
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  rate_speed_e           curr_data_rate_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [KEEP_WIDTH-1:0] data_k_i,
  input  logic                  data_valid_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  framing_err_o,
  output logic [15:0]           err_count_o
);

  localparam int unsigned CntW = $clog2(MAX_TLP_WORDS + 1);
  localparam logic [7:0] SymStp = 8'hFB;
  localparam logic [7:0] SymSdp = 8'h5C;
  localparam logic [7:0] SymEnd = 8'hFD;
  localparam logic [7:0] SymEdb = 8'hFE;

  typedef enum logic [1:0] {StIdle, StDllpBody, StTlpBody} state_e;

  state_e          r_state;
  logic [23:0]     r_hold;
  logic [CntW-1:0] r_cnt;
  logic [15:0]     r_tail;
  logic            r_tail_pending;
  logic            r_tail_err;
  logic            r_tail_dllp;
  logic [15:0]     r_err_cnt;

  logic [7:0]  w_b [4];
  logic        w_rate_ok;
  logic        w_start_stp;
  logic        w_start0;
  logic        w_start_mis;
  logic        w_end;
  logic        w_body_err;
  logic        w_in_dllp;
  logic [15:0] w_err_cnt_inc;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_b[i] = data_i[8*i +: 8];
    end
    w_start_mis = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (data_k_i[i] && (w_b[i] == SymStp || w_b[i] == SymSdp)) begin
        w_start_mis = 1'b1;
      end
    end
  end

  assign w_rate_ok   = (curr_data_rate_i == RateGen1) || (curr_data_rate_i == RateGen2);
  assign w_start_stp = data_k_i[0] && (w_b[0] == SymStp);
  assign w_start0    = w_start_stp || (data_k_i[0] && (w_b[0] == SymSdp));
  assign w_end       = (data_k_i == 4'b1000) && (w_b[3] == SymEnd || w_b[3] == SymEdb);
  assign w_in_dllp   = (r_state == StDllpBody);
  // A DLLP has exactly one body word (the END word); a TLP may not run to its word limit.
  assign w_body_err  = (|data_k_i) || w_in_dllp || (r_cnt == CntW'(MAX_TLP_WORDS - 1));
  assign w_err_cnt_inc = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

  assign err_count_o = r_err_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state        <= StIdle;
      r_hold         <= '0;
      r_cnt          <= '0;
      r_tail         <= '0;
      r_tail_pending <= 1'b0;
      r_tail_err     <= 1'b0;
      r_tail_dllp    <= 1'b0;
      r_err_cnt      <= '0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= '0;
      framing_err_o  <= 1'b0;
    end else begin
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= '0;
      framing_err_o  <= 1'b0;
      r_tail_pending <= 1'b0;

      // Start words never emit, so the tail slot cannot collide with new output.
      if (r_tail_pending) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {16'h0000, r_tail};
        m_axis_tkeep  <= 4'b0011;
        m_axis_tlast  <= 1'b1;
        m_axis_tuser  <= {{(USER_WIDTH - 2){1'b0}}, r_tail_err, r_tail_dllp};
      end

      if (!w_rate_ok) begin
        r_state <= StIdle;
      end else if (data_valid_i) begin
        unique case (r_state)
          StIdle: begin
            if (w_start0) begin
              r_state <= w_start_stp ? StTlpBody : StDllpBody;
              r_hold  <= data_i[31:8];
              r_cnt   <= CntW'(1);
            end else if (w_start_mis) begin
              framing_err_o <= 1'b1;
              r_err_cnt     <= w_err_cnt_inc;
            end
          end
          default: begin
            if (w_start0 || (!w_end && w_body_err)) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {8'h00, r_hold};
              m_axis_tkeep  <= 4'b0111;
              m_axis_tlast  <= 1'b1;
              m_axis_tuser  <= {{(USER_WIDTH - 2){1'b0}}, 1'b1, w_in_dllp};
              framing_err_o <= 1'b1;
              r_err_cnt     <= w_err_cnt_inc;
              if (w_start0) begin
                r_state <= w_start_stp ? StTlpBody : StDllpBody;
                r_hold  <= data_i[31:8];
                r_cnt   <= CntW'(1);
              end else begin
                r_state <= StIdle;
              end
            end else if (w_end) begin
              m_axis_tvalid  <= 1'b1;
              m_axis_tdata   <= {w_b[0], r_hold};
              m_axis_tkeep   <= 4'b1111;
              m_axis_tuser   <= {{(USER_WIDTH - 1){1'b0}}, w_in_dllp};
              r_tail         <= data_i[23:8];
              r_tail_pending <= 1'b1;
              r_tail_err     <= (w_b[3] == SymEdb);
              r_tail_dllp    <= w_in_dllp;
              r_state        <= StIdle;
            end else begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {w_b[0], r_hold};
              m_axis_tkeep  <= 4'b1111;
              r_hold        <= data_i[31:8];
              r_cnt         <= r_cnt + CntW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/phy_rx_deframe.md
Name: phy_rx_deframe

Overview:
- Receive-side counterpart of the transmit framing path.
- Takes 8b/10b-domain (2.5/5.0 GT/s) descrambled, deskewed, lane-merged symbol words.
- Finds STP/SDP…END/EDB framed packets and strips the framing symbols.
- Re-aligns the payload bytes and presents each packet as an AXIS stream to the data link layer receive FIFO. It runs in the PIPE RX user clock domain.

Parameters:
- DATA_WIDTH, 32, symbol word width; only 32 is supported (4 symbols per word, byte 0 earliest).
- KEEP_WIDTH, DATA_WIDTH/8, K-flag and tkeep width.
- USER_WIDTH, 5, AXIS tuser width.
- MAX_TLP_WORDS, 1040, maximum input words per TLP frame, including the start and END words.

Ports:
- clk_i  in  1  PIPE RX user clock; the single clock of the block.
- rst_i  in  1  reset, asynchronous, active-low.
- curr_data_rate_i  in  rate_speed_e  current link rate.
- data_i  in  DATA_WIDTH  symbol word.
- data_k_i  in  KEEP_WIDTH  per-byte K flag.
- data_valid_i  in  1  word qualifier.
- m_axis_tdata  out  DATA_WIDTH  payload bytes.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tlast  out  1  last word of packet.
- m_axis_tuser  out  USER_WIDTH  [0]=DLLP(1)/TLP(0), [1]=error/nullified, others 0.
- framing_err_o  out  1  one-cycle framing error pulse.
- err_count_o  out  16  saturating framing error count.

Behaviour:
- Reset (rst_i low, async): all outputs 0, state IDLE, hold and tail registers cleared. Outputs are registered.
- No backpressure. Downstream must accept every m_axis_tvalid word.
- Symbols:
  - STP = K 0xFB, SDP = K 0x5C, END = K 0xFD, EDB = K 0xFE.
  - All other K symbols (COM, SKP, IDL, FTS) are ignored outside a frame.
- Rate gating: if curr_data_rate_i is not Gen1 or Gen2, inputs are ignored, state is forced to IDLE and no output is produced.
- Cycles with data_valid_i=0 are ignored; all state is held.
- Frames are word-aligned: the start symbol is in byte 0 and END/EDB is in byte 3.
  - A start symbol in bytes 1-3 while IDLE: framing_err_o pulses and the word is dropped.
- Hold register: 3 bytes. A start word loads bytes 1-3 into hold and emits nothing. The word counter is set to 1.
- Body word in DLLP_BODY or TLP_BODY (no K flags):
  - Emit {hold[0..2], byte0} with keep 1111, one cycle after input.
  - Load bytes 1-3 into hold; counter increments.
- END word (K only on byte 3, 0xFD):
  - Cycle +1: emit {hold, byte0}, keep 1111.
  - Set tail_pending with bytes 1-2.
  - Cycle +2: emit the tail with keep 0011 and tlast=1, unconditionally.
  - Go IDLE.
  - The start word of a back-to-back frame may arrive in the tail cycle; it emits nothing, so there is no slot conflict.
- EDB word: same sequence as END, but tuser[1]=1 on the tail word. This is not counted as a framing error.
- DLLP (SDP) frame: must end exactly on input word 2. Output is 2 words (keep 1111, then keep 0011) with tuser[0]=1.
- Framing errors:
  - Any K symbol in a body word other than END/EDB at byte 3.
  - END/EDB in bytes 0-2.
  - SDP frame not ending on word 2.
  - TLP counter reaching MAX_TLP_WORDS without END.
  - A byte-0 STP/SDP while a frame is open.
- On a framing error while a frame is open:
  - Emit {hold, 0} with keep 0111, tlast=1, tuser[1]=1.
  - framing_err_o pulses and err_count_o increments, saturating at 0xFFFF.
  - If the offending word is a byte-0 start symbol, the new frame starts that same cycle. Otherwise go IDLE.
- FSM:
  - IDLE → DLLP_BODY on SDP, IDLE → TLP_BODY on STP.
  - Body → IDLE on END, EDB or error.
  - tail_pending is an independent flag, cleared after one cycle.

Test Plan:
- DLLP: SDP,00,00,00 | 00,12,34,FD(K) → out 0x000000_00 keep 1111, then 0x34_12 keep 0011 tlast=1, tuser=01, at cycles +1/+2.
- TLP: STP plus 3 body words then END word (20 bytes) → 5 output words: 4 with keep 1111, the last with keep 0011 tlast, tuser=00; no framing_err_o.
- EDB-terminated TLP → same word count, last word tuser[1]=1, err_count_o unchanged.
- Back-to-back: DLLP END word immediately followed by an SDP word → tail emitted in the SDP cycle, second DLLP output intact; COM/SKP between frames produce nothing.
- Errors:
  - K 0x7C in byte 1 mid-TLP → terminating word keep 0111 tlast tuser[1]=1, framing_err_o one pulse, err_count_o=1.
  - STP in byte 2 while IDLE → dropped, err_count_o=2.
- Reset/rate: rst_i low mid-TLP → tvalid=0 immediately, next SDP frame decodes correctly; rate set to Gen3 → no outputs for any input.
